// File: rtl/piso_serializer.sv
// piso_serializer: valid/ready loaded parallel-in/serial-out shifter with stall and gapless back-to-back words
module piso_serializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_data,
  input  logic             shift_en,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             ser_last,
  output logic             busy
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] PEN  = CW'(WIDTH - 2);
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] sr;
  logic             accept;
  function automatic logic head(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? w[WIDTH-1] : w[0];
  endfunction
  function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? {w[WIDTH-2:0], 1'b0} : {1'b0, w[WIDTH-1:1]};
  endfunction
  assign load_ready = (state == IDLE) | ((state == SHIFT) & ser_last & shift_en);
  assign accept     = load_valid & load_ready;
  assign busy       = ser_valid;
  // word load, bit advance, stall hold and end-of-word return to idle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      sr        <= '0;
      ser_out   <= 1'b0;
      ser_valid <= 1'b0;
      ser_last  <= 1'b0;
    end else if (accept) begin
      state     <= SHIFT;
      cnt       <= '0;
      sr        <= advance(load_data);
      ser_out   <= head(load_data);
      ser_valid <= 1'b1;
      ser_last  <= 1'b0;
    end else if (state == SHIFT && shift_en) begin
      if (cnt == LAST) begin
        state     <= IDLE;
        cnt       <= '0;
        ser_valid <= 1'b0;
        ser_last  <= 1'b0;
      end else begin
        cnt      <= cnt + 1'b1;
        sr       <= advance(sr);
        ser_out  <= head(sr);
        ser_last <= (cnt == PEN);
      end
    end
  end
endmodule

// File: tb/tb_piso_serializer.sv
// tb_piso_serializer: directed checks of load, shift, stall, back-to-back, async reset and LSB-first order
module tb_piso_serializer;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       lv = 1'b0, se = 1'b0;
  logic [7:0] ld = '0;
  logic       rdy, so, sv, sl, bsy;
  logic       lv2 = 1'b0, se2 = 1'b0;
  logic [3:0] ld2 = '0;
  logic       rdy2, so2, sv2, sl2, bsy2;
  int         total = 0, passed = 0;
  logic [15:0] exp16;
  logic [10:0] exp11;
  logic [3:0]  exp4;

  always #5 clk = ~clk;

  piso_serializer #(.WIDTH(8), .MSB_FIRST(1)) dut (
    .clk(clk), .rst_n(rst_n), .load_valid(lv), .load_ready(rdy), .load_data(ld),
    .shift_en(se), .ser_out(so), .ser_valid(sv), .ser_last(sl), .busy(bsy)
  );

  piso_serializer #(.WIDTH(4), .MSB_FIRST(0)) dut2 (
    .clk(clk), .rst_n(rst_n), .load_valid(lv2), .load_ready(rdy2), .load_data(ld2),
    .shift_en(se2), .ser_out(so2), .ser_valid(sv2), .ser_last(sl2), .busy(bsy2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // T1 reset before any edge
    #2;
    chk("t1_valid", {31'd0, sv}, 0);
    chk("t1_last", {31'd0, sl}, 0);
    chk("t1_busy", {31'd0, bsy}, 0);
    chk("t1_ready", {31'd0, rdy}, 1);
    chk("t1_out", {31'd0, so}, 0);
    chk("t1_ready2", {31'd0, rdy2}, 1);
    step();
    rst_n = 1'b1;
    step();
    chk("idle_valid", {31'd0, sv}, 0);

    // T2 single word 8'hA5 MSB first
    ld = 8'hA5; lv = 1'b1; se = 1'b1;
    chk("t2_ready_idle", {31'd0, rdy}, 1);
    step();
    lv = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("t2_bit%0d", i), {31'd0, so}, (8'hA5 >> (7 - i)) & 1);
      chk($sformatf("t2_valid%0d", i), {31'd0, sv}, 1);
      chk($sformatf("t2_last%0d", i), {31'd0, sl}, (i == 7) ? 1 : 0);
      step();
    end
    chk("t2_end_valid", {31'd0, sv}, 0);
    chk("t2_end_last", {31'd0, sl}, 0);
    chk("t2_end_busy", {31'd0, bsy}, 0);

    // T3 back-to-back F0 then 0F
    exp16 = 16'b11110000_00001111;
    ld = 8'hF0; lv = 1'b1;
    step();
    ld = 8'h0F;
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("t3_bit%0d", i), {31'd0, so}, {31'd0, exp16[15 - i]});
      chk($sformatf("t3_valid%0d", i), {31'd0, sv}, 1);
      chk($sformatf("t3_ready%0d", i), {31'd0, rdy}, (i == 7 || i == 15) ? 1 : 0);
      chk($sformatf("t3_last%0d", i), {31'd0, sl}, (i == 7 || i == 15) ? 1 : 0);
      step();
      if (i == 7) lv = 1'b0;
    end
    chk("t3_end_valid", {31'd0, sv}, 0);

    // T4 stall three cycles after bit 2 of A5
    exp11 = 11'b101_1110_0101;
    ld = 8'hA5; lv = 1'b1; se = 1'b1;
    step();
    lv = 1'b0;
    for (int k = 0; k < 11; k++) begin
      se = (k >= 2 && k <= 4) ? 1'b0 : 1'b1;
      #1;
      chk($sformatf("t4_bit%0d", k), {31'd0, so}, {31'd0, exp11[10 - k]});
      chk($sformatf("t4_valid%0d", k), {31'd0, sv}, 1);
      chk($sformatf("t4_last%0d", k), {31'd0, sl}, (k == 10) ? 1 : 0);
      chk($sformatf("t4_ready%0d", k), {31'd0, rdy}, (k == 10) ? 1 : 0);
      step();
    end
    chk("t4_end_valid", {31'd0, sv}, 0);
    se = 1'b1;

    // T5 async reset after bit 4 of FF
    ld = 8'hFF; lv = 1'b1;
    step();
    lv = 1'b0;
    for (int i = 0; i < 4; i++) step();
    chk("t5_bit4_valid", {31'd0, sv}, 1);
    chk("t5_bit4", {31'd0, so}, 1);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_valid", {31'd0, sv}, 0);
    chk("t5_rst_busy", {31'd0, bsy}, 0);
    chk("t5_rst_last", {31'd0, sl}, 0);
    chk("t5_rst_ready", {31'd0, rdy}, 1);
    step();
    #2 rst_n = 1'b1;
    chk("t5_rel_ready", {31'd0, rdy}, 1);
    for (int i = 0; i < 6; i++) begin
      step();
      chk($sformatf("t5_residual%0d", i), {31'd0, sv}, 0);
    end

    // T6 LSB first, WIDTH 4, load ignored mid-word
    exp4 = 4'b0001;
    ld2 = 4'b0001; lv2 = 1'b1; se2 = 1'b1;
    step();
    lv2 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i == 1) begin ld2 = 4'b1110; lv2 = 1'b1; end
      if (i == 2) lv2 = 1'b0;
      #1;
      if (i == 1) chk("t6_ready_mid", {31'd0, rdy2}, 0);
      chk($sformatf("t6_bit%0d", i), {31'd0, so2}, {31'd0, exp4[i]});
      chk($sformatf("t6_valid%0d", i), {31'd0, sv2}, 1);
      chk($sformatf("t6_last%0d", i), {31'd0, sl2}, (i == 3) ? 1 : 0);
      step();
    end
    chk("t6_end_valid", {31'd0, sv2}, 0);
    step();
    chk("t6_no_late_accept", {31'd0, sv2}, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
